// File: rtl/wb_arbiter2_pkg.sv
// Shared definitions for the two-master Wishbone peripheral arbiter.
package wb_arbiter2_pkg;

  // The grant states are one-hot so the state register doubles as gnt_o.
  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_GNT0 = 2'b01,
    ARB_GNT1 = 2'b10
  } arb_state_e;

  localparam logic        RstEnable = 1'b0;
  localparam logic [31:0] ZeroWord  = 32'h0000_0000;

endpackage

// File: rtl/wb_arbiter2.sv
// Two-master, one-slave Wishbone arbiter in front of the peripheral decoder.
// Round-robin with the bus locked for the whole cycle, registered grant.
// Optional watchdog: define WB_ARB_TIMEOUT_EN to abort stalled cycles with err.
module wb_arbiter2
  import wb_arbiter2_pkg::*;
#(
  parameter int unsigned AW             = 32,
  parameter int unsigned DW             = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  // master 0 (CPU data bus)
  input  logic              m0_cyc_i,
  input  logic              m0_stb_i,
  input  logic              m0_we_i,
  input  logic [AW-1:0]     m0_adr_i,
  input  logic [DW-1:0]     m0_dat_i,
  input  logic [DW/8-1:0]   m0_sel_i,
  output logic [DW-1:0]     m0_dat_o,
  output logic              m0_ack_o,
  output logic              m0_err_o,
  // master 1 (debug / DMA)
  input  logic              m1_cyc_i,
  input  logic              m1_stb_i,
  input  logic              m1_we_i,
  input  logic [AW-1:0]     m1_adr_i,
  input  logic [DW-1:0]     m1_dat_i,
  input  logic [DW/8-1:0]   m1_sel_i,
  output logic [DW-1:0]     m1_dat_o,
  output logic              m1_ack_o,
  output logic              m1_err_o,
  // shared slave port
  output logic              s_cyc_o,
  output logic              s_stb_o,
  output logic              s_we_o,
  output logic [AW-1:0]     s_adr_o,
  output logic [DW-1:0]     s_dat_o,
  output logic [DW/8-1:0]   s_sel_o,
  input  logic [DW-1:0]     s_dat_i,
  input  logic              s_ack_i,
  output logic [1:0]        gnt_o
);

  arb_state_e state, state_nxt;
  logic       last_gnt, last_gnt_nxt;  // 0 = m0 held the bus last, 1 = m1
  logic       timeout;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] wd_cnt;
  logic          stall;

  // Granted master is strobing and the slave has not answered this cycle.
  always_comb begin
    stall = 1'b0;
    if (state == ARB_GNT0) stall = m0_stb_i & ~s_ack_i;
    if (state == ARB_GNT1) stall = m1_stb_i & ~s_ack_i;
  end

  // Fire on the stalled cycle that brings the count up to TIMEOUT_CYCLES.
  assign timeout = stall && (wd_cnt == CW'(TIMEOUT_CYCLES - 1));

  // Watchdog counter: cleared while idle (i.e. on grant entry) and on ack.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (wb_rst_i == RstEnable) begin
      wd_cnt <= '0;
    end else if (state == ARB_IDLE || s_ack_i || timeout) begin
      wd_cnt <= '0;
    end else if (stall) begin
      wd_cnt <= wd_cnt + CW'(1);
    end
  end
`else
  logic unused_timeout_cfg;

  assign timeout            = 1'b0;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  // Grant state and round-robin history.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (wb_rst_i == RstEnable) begin
      state    <= ARB_IDLE;
      last_gnt <= 1'b1;
    end else begin
      state    <= state_nxt;
      last_gnt <= last_gnt_nxt;
    end
  end

  // Next grant: arbitrate only in IDLE, hold the grant until cyc drops.
  always_comb begin
    state_nxt    = state;
    last_gnt_nxt = last_gnt;
    case (state)
      ARB_IDLE: begin
        if (m0_cyc_i && m1_cyc_i) state_nxt = last_gnt ? ARB_GNT0 : ARB_GNT1;
        else if (m0_cyc_i)        state_nxt = ARB_GNT0;
        else if (m1_cyc_i)        state_nxt = ARB_GNT1;
      end
      ARB_GNT0: begin
        if (!m0_cyc_i || timeout) begin
          state_nxt    = ARB_IDLE;
          last_gnt_nxt = 1'b0;
        end
      end
      ARB_GNT1: begin
        if (!m1_cyc_i || timeout) begin
          state_nxt    = ARB_IDLE;
          last_gnt_nxt = 1'b1;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  // Slave-side mux from the granted master; everything 0 when idle.
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    case (state)
      ARB_GNT0: begin
        s_cyc_o = m0_cyc_i & ~timeout;
        s_stb_o = m0_stb_i & ~timeout;
        s_we_o  = m0_we_i;
        s_adr_o = m0_adr_i;
        s_dat_o = m0_dat_i;
        s_sel_o = m0_sel_i;
      end
      ARB_GNT1: begin
        s_cyc_o = m1_cyc_i & ~timeout;
        s_stb_o = m1_stb_i & ~timeout;
        s_we_o  = m1_we_i;
        s_adr_o = m1_adr_i;
        s_dat_o = m1_dat_i;
        s_sel_o = m1_sel_i;
      end
      default: ;
    endcase
  end

  assign gnt_o    = state;
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = s_ack_i & gnt_o[0];
  assign m1_ack_o = s_ack_i & gnt_o[1];
  assign m0_err_o = timeout & gnt_o[0];
  assign m1_err_o = timeout & gnt_o[1];

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed bench for wb_arbiter2 with a combinational-ack peripheral model.
// Build with WB_ARB_TIMEOUT_EN defined to also exercise the watchdog.
module tb_wb_arbiter2;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int unsigned TMO = 8;
`else
  localparam int unsigned TMO = 255;
`endif

  logic        clk, rst_n;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [31:0] m0_adr, m0_wdat, m1_adr, m1_wdat;
  logic [3:0]  m0_sel, m1_sel;
  logic [31:0] m0_rdat, m1_rdat;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic        s_cyc, s_stb, s_we;
  logic [31:0] s_adr, s_wdat, s_rdat;
  logic [3:0]  s_sel;
  logic        s_ack;
  logic [1:0]  gnt;

  logic        ack_en;
  int          wr_cnt;
  logic [31:0] wr_last;
  int          vectors, miscompares;
  logic        seen;

  wb_arbiter2 #(.AW(32), .DW(32), .TIMEOUT_CYCLES(TMO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst_n),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
    .m0_dat_i(m0_wdat), .m0_sel_i(m0_sel), .m0_dat_o(m0_rdat), .m0_ack_o(m0_ack),
    .m0_err_o(m0_err),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
    .m1_dat_i(m1_wdat), .m1_sel_i(m1_sel), .m1_dat_o(m1_rdat), .m1_ack_o(m1_ack),
    .m1_err_o(m1_err),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_adr_o(s_adr),
    .s_dat_o(s_wdat), .s_sel_o(s_sel), .s_dat_i(s_rdat), .s_ack_i(s_ack),
    .gnt_o(gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Peripheral model: switch register at 0xF020 reads 0xA5, others read a tag.
  assign s_ack  = ack_en & s_cyc & s_stb;
  assign s_rdat = (s_adr == 32'h0000_F020) ? 32'h0000_00A5 : {16'hD0D0, s_adr[15:0]};

  // Record acknowledged writes.
  always @(posedge clk) begin
    if (s_ack && s_we) begin
      wr_cnt  <= wr_cnt + 1;
      wr_last <= s_wdat;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_masters();
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_wdat = '0; m0_sel = 4'hF;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_wdat = '0; m1_sel = 4'hF;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    clear_masters();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    vectors = 0; miscompares = 0; wr_cnt = 0; wr_last = '0; ack_en = 1'b1;
    rst_n = 1'b0;
    clear_masters();

    // Reset state
    #3;
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_s_cyc", 32'({s_cyc, s_stb}), 32'h0);
    check("rst_s_adr", s_adr, 32'h0);
    check("rst_ack_err", 32'({m1_err, m1_ack, m0_err, m0_ack}), 32'h0);
    @(negedge clk) rst_n = 1'b1;

    // T1: single m0 read of the switch register
    @(posedge clk); #1;
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0000_F020;
    @(negedge clk);
    check("t1_s_cyc_n", 32'(s_cyc), 32'h0);
    check("t1_gnt_n", 32'(gnt), 32'h0);
    @(negedge clk);
    check("t1_s_cyc_n1", 32'(s_cyc), 32'h1);
    check("t1_gnt", 32'(gnt), 32'h1);
    check("t1_m0_ack", 32'(m0_ack), 32'h1);
    check("t1_m0_dat", m0_rdat, 32'h0000_00A5);
    check("t1_s_adr", s_adr, 32'h0000_F020);
    check("t1_s_sel", 32'(s_sel), 32'hF);
    check("t1_m1_ack", 32'(m1_ack), 32'h0);
    @(posedge clk); #1;
    m0_cyc = 0; m0_stb = 0;
    @(negedge clk);
    check("t1_s_cyc_drop", 32'(s_cyc), 32'h0);

    // T2: simultaneous request after reset, m0 wins then m1 after one idle cycle
    do_reset();
    @(posedge clk); #1;
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0000_F020;
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h0000_F004;
    @(negedge clk);
    check("t2_gnt_idle", 32'(gnt), 32'h0);
    @(negedge clk);
    check("t2_gnt_m0", 32'(gnt), 32'h1);
    check("t2_acks_m0", 32'({m1_ack, m0_ack}), 32'h1);
    @(posedge clk); #1;
    m0_cyc = 0; m0_stb = 0;
    @(negedge clk);
    check("t2_m1_wait_a", 32'(m1_ack), 32'h0);
    @(negedge clk);
    check("t2_gnt_dead", 32'(gnt), 32'h0);
    check("t2_m1_wait_b", 32'(m1_ack), 32'h0);
    @(negedge clk);
    check("t2_gnt_m1", 32'(gnt), 32'h2);
    check("t2_m1_ack", 32'(m1_ack), 32'h1);
    check("t2_m1_dat", m1_rdat, 32'hD0D0_F004);
    @(posedge clk); #1;
    m1_cyc = 0; m1_stb = 0;
    @(negedge clk);

    // T3: both request continuously, grants alternate
    @(posedge clk); #1;
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    for (int i = 0; i < 4; i++) begin
      logic [1:0] exp_gnt;
      exp_gnt = (i % 2 == 0) ? 2'b01 : 2'b10;
      seen = 1'b0;
      for (int k = 0; k < 8 && !seen; k++) begin
        @(negedge clk);
        if (gnt != 2'b00) seen = 1'b1;
      end
      check("t3_gnt_seen", 32'(seen), 32'h1);
      check("t3_gnt", 32'(gnt), 32'(exp_gnt));
      check("t3_acks", 32'({m1_ack, m0_ack}), 32'(exp_gnt));
      @(posedge clk); #1;
      if (exp_gnt == 2'b01) begin m0_cyc = 0; m0_stb = 0; end
      else begin m1_cyc = 0; m1_stb = 0; end
      @(negedge clk);
      check("t3_acks_rel", 32'({m1_ack, m0_ack}), 32'h0);
      @(posedge clk); #1;
      if (i < 3) begin
        if (exp_gnt == 2'b01) begin m0_cyc = 1; m0_stb = 1; end
        else begin m1_cyc = 1; m1_stb = 1; end
      end else begin
        clear_masters();
      end
    end

    // T4: m1 locked write burst with stb gaps while m0 waits
    @(posedge clk); #1;
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = 32'h0000_F000; m1_wdat = 32'h1111_1111;
    @(negedge clk);
    @(negedge clk);
    check("t4_gnt_w1", 32'(gnt), 32'h2);
    check("t4_ack_w1", 32'(m1_ack), 32'h1);
    check("t4_s_we", 32'(s_we), 32'h1);
    check("t4_s_dat_w1", s_wdat, 32'h1111_1111);
    @(posedge clk); #1;
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0000_F020;
    for (int w = 2; w <= 3; w++) begin
      m1_stb = 0;
      @(negedge clk);
      check("t4_gnt_gap", 32'(gnt), 32'h2);
      check("t4_s_cyc_stb_gap", 32'({s_cyc, s_stb}), 32'h2);
      check("t4_m0_ack_gap", 32'(m0_ack), 32'h0);
      @(posedge clk); #1;
      m1_stb = 1; m1_wdat = 32'h1111_1111 * w;
      @(negedge clk);
      check("t4_gnt_w", 32'(gnt), 32'h2);
      check("t4_ack_w", 32'({m1_ack, m0_ack}), 32'h2);
      check("t4_s_dat_w", s_wdat, 32'h1111_1111 * w);
      @(posedge clk); #1;
    end
    m1_cyc = 0; m1_stb = 0; m1_we = 0;
    @(negedge clk);
    check("t4_m0_ack_rel", 32'(m0_ack), 32'h0);
    @(negedge clk);
    check("t4_gnt_dead", 32'(gnt), 32'h0);
    @(negedge clk);
    check("t4_gnt_m0", 32'(gnt), 32'h1);
    check("t4_m0_ack", 32'(m0_ack), 32'h1);
    check("t4_wr_cnt", 32'(wr_cnt), 32'd3);
    check("t4_wr_last", wr_last, 32'h3333_3333);

    // T5: m0 releases (history = m0), m1 granted, reset asserted mid-grant
    @(posedge clk); #1;
    m0_cyc = 0; m0_stb = 0;
    @(negedge clk);
    @(posedge clk); #1;
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h0000_F004;
    @(negedge clk);
    @(negedge clk);
    check("t5_gnt_m1", 32'(gnt), 32'h2);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_gnt", 32'(gnt), 32'h0);
    check("t5_rst_s_cyc", 32'({s_cyc, s_stb}), 32'h0);
    check("t5_rst_acks", 32'({m1_ack, m0_ack}), 32'h0);
    @(posedge clk); #1;
    m1_cyc = 0; m1_stb = 0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    @(negedge clk);
    @(negedge clk);
    check("t5_tie_after_rst", 32'(gnt), 32'h1);
    @(posedge clk); #1;
    clear_masters();

`ifdef WB_ARB_TIMEOUT_EN
    // T6: hung slave, watchdog aborts m0 on the 8th stalled cycle
    do_reset();
    ack_en = 1'b0;
    @(posedge clk); #1;
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0000_F010;
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h0000_F004;
    @(negedge clk);
    check("t6_gnt_idle", 32'(gnt), 32'h0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check("t6_gnt_m0", 32'(gnt), 32'h1);
      check("t6_err", 32'({m1_err, m0_err}), (k == 8) ? 32'h1 : 32'h0);
      check("t6_s_cyc", 32'(s_cyc), (k == 8) ? 32'h0 : 32'h1);
    end
    @(posedge clk); #1;
    m0_cyc = 0; m0_stb = 0;
    @(negedge clk);
    check("t6_gnt_dead", 32'(gnt), 32'h0);
    @(negedge clk);
    check("t6_gnt_m1", 32'(gnt), 32'h2);
    check("t6_m1_err", 32'({m1_err, m0_err}), 32'h0);
    @(posedge clk); #1;
    clear_masters();
    ack_en = 1'b1;
`endif

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
